memory_v3: RTL and testbench
============================

Name: memory_v3

Overview:
Parametrised successor memory unit for the RISC-V core's data side. It contains:
- word-addressed synchronous RAM
- N_OUT memory-mapped output port registers, each driving a seven-segment digit
- N_IN memory-mapped input ports with two-flop synchronisers
- a sticky error/status register

The core accesses it through a single request port. Reads return after one cycle, qualified by rd_valid.

Parameters:
ADDR_WIDTH, 12, word address width; address space is 2**ADDR_WIDTH words
DATA_WIDTH, 32, data word width (at least 8)
RAM_DEPTH, 1024, RAM words starting at address 0; must be at most 2**ADDR_WIDTH - 64
N_OUT, 8, output port count, 1..32
N_IN, 4, input port count, 1..16

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  reset, synchronous, active-low
mem_addr  in  ADDR_WIDTH  word address
data_in  in  DATA_WIDTH  write data
write_enable  in  1  write strobe, one access per cycle
read_enable  in  1  read strobe
data_out  out  DATA_WIDTH  read data, registered
rd_valid  out  1  data_out valid this cycle
in_ports  in  N_IN*DATA_WIDTH  asynchronous input ports, flattened; port k at [k*DATA_WIDTH +: DATA_WIDTH]
out_ports  out  N_OUT*DATA_WIDTH  output port registers, flattened
seg  out  N_OUT*7  seven-segment drive; digit k at [k*7 +: 7]
memory_error_vector  out  8  sticky error flags

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low: state clears on a rising clk edge while rst==0.
- Reset values: data_out=0, rd_valid=0, out_ports=0, memory_error_vector=0, synchroniser flops=0. RAM contents are not reset.
- Address map, with IO_BASE = 2**ADDR_WIDTH - 64:
  - RAM: [0, RAM_DEPTH)
  - OUTPORT k: IO_BASE+k, read/write
  - INPORT k: IO_BASE+32+k, read-only
  - ERR: IO_BASE+63; reads return the error vector zero-extended; writes are write-1-to-clear on bits [6:0]
  - Everything else is unmapped.
- Write (write_enable=1, read_enable=0):
  - target updates at that edge
  - RAM and OUTPORT take data_in
  - the new out_ports value is visible the next cycle
- Read (read_enable=1, write_enable=0):
  - data_out and rd_valid=1 are presented exactly one cycle after the request edge; rd_valid pulses for one cycle per read
  - back-to-back reads are fully pipelined, one per cycle
  - data_out holds its last value when rd_valid=0
- Read-after-write to the same address on consecutive cycles returns the new data.
- Simultaneous read_enable and write_enable: the write is performed, the read is dropped (rd_valid=0 next cycle), and err bit 0 is set.
- Write to an INPORT: ignored, sets err bit 1.
- Access to an unmapped address: write ignored; read returns 0 with rd_valid=1; sets err bit 2.
- Input synchronisation: in_ports pass through two flops per bit. An INPORT read returns the second-stage value. Total input-to-data_out latency is at most 3 cycles plus the read cycle.
- Error register:
  - bits [2:0] as above, bits [6:3] reserved (0)
  - bit 7 = OR of bits [6:0], combinational from the flags
  - flags are sticky until W1C or reset
  - a new error in the same cycle as a W1C of that bit: set wins
- seg (without option): digit k = out_ports[k][6:0].
- Reset mid-read: rd_valid is 0 in the cycle after reset is sampled low.

Optional Feature:
MEMORY_V3_SEG_DECODE_EN
- Defined: digit k = hex-to-seven-segment decode of out_ports[k][3:0], active-low segments, order {g,f,e,d,c,b,a}. Example: 0x0 -> 7'b1000000.
- Undefined: raw mapping as above; no decoder logic generated.

Decomposition:
- Package memory_v3_pkg:
  - IO region offsets (OUT_OFS=0, IN_OFS=32, ERR_OFS=63, IO_SPAN=64)
  - error bit indices ERR_RW_CONFLICT=0, ERR_RO_WRITE=1, ERR_UNMAPPED=2, ERR_ANY=7
  - typedef for an address region enum {REG_RAM, REG_OUT, REG_IN, REG_ERR, REG_NONE}
  - hex-to-seg function
- Sub-module mem_io_sync: a parametrised-width two-flop synchroniser, instantiated per input port.
- Address decode and RAM stay inline.

Test Plan:
- Write 0xDEADBEEF to addr 5, read 5 next cycle -> rd_valid=1 one cycle later, data_out=0xDEADBEEF.
- Write 0x3 to IO_BASE+1 -> out_ports[1]=0x3 next cycle; seg digit 1 = 7'b0000011 raw, or 7'b0110000 with MEMORY_V3_SEG_DECODE_EN.
- Drive in_ports[2]=0xA5, wait 2 cycles, read IO_BASE+34 -> data_out=0xA5. Read issued 1 cycle after the change -> returns the old value.
- Assert read and write to addr 7 together with data 0x11 -> RAM[7]=0x11, no rd_valid, error vector=0x81. Write 0x01 to ERR -> 0x00.
- Write to IO_BASE+32, then read addr RAM_DEPTH -> error vector=0x86. The read returns 0 with rd_valid=1.
- Hold rst=0 for one edge during back-to-back reads -> rd_valid=0, out_ports=0 and error vector=0 the next cycle; RAM data preserved.

Source files
------------

// File: rtl/memory_v3_pkg.sv
// memory_v3 shared definitions: IO region offsets, error bit indices,
// address region type and the hex-to-seven-segment helper.
package memory_v3_pkg;

  localparam int OUT_OFS = 0;
  localparam int IN_OFS  = 32;
  localparam int ERR_OFS = 63;
  localparam int IO_SPAN = 64;

  localparam int ERR_RW_CONFLICT = 0;
  localparam int ERR_RO_WRITE    = 1;
  localparam int ERR_UNMAPPED    = 2;
  localparam int ERR_ANY         = 7;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_OUT,
    REG_IN,
    REG_ERR,
    REG_NONE
  } region_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_io_sync.sv
// Two-flop synchroniser for one asynchronous input port.
// Synchronous active-low reset clears both stages.
module mem_io_sync #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  // Shift the asynchronous value through two stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/memory_v3.sv
// memory_v3: data-side RAM, output/input port registers and sticky errors.
// Option MEMORY_V3_SEG_DECODE_EN: hex-decode seg digits instead of raw bits.
module memory_v3
  import memory_v3_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 1024,
  parameter int N_OUT      = 8,
  parameter int N_IN       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       write_enable,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       rd_valid,
  input  logic [N_IN*DATA_WIDTH-1:0] in_ports,
  output logic [N_OUT*DATA_WIDTH-1:0] out_ports,
  output logic [N_OUT*7-1:0]         seg,
  output logic [7:0]                 memory_error_vector
);

  localparam int OW  = $clog2(IO_SPAN);
  localparam int RAW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RAM_TOP = ADDR_WIDTH'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] r_ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_out [N_OUT];
  logic [DATA_WIDTH-1:0] w_in  [N_IN];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rv;
  logic [2:0]            r_err;

  logic [OW-1:0]         w_ofs;
  logic                  w_io;
  logic [RAW-1:0]        w_ram_idx;
  region_e               w_region;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [2:0]            w_set;
  logic [2:0]            w_clr;
  logic [7:0]            w_err_vec;

  assign w_ofs     = mem_addr[OW-1:0];
  assign w_io      = &mem_addr[ADDR_WIDTH-1:OW];
  assign w_ram_idx = mem_addr[RAW-1:0];
  assign w_rd      = read_enable & ~write_enable;

  // Classify the request address into a region
  always_comb begin
    w_region = REG_NONE;
    if (mem_addr < RAM_TOP) begin
      w_region = REG_RAM;
    end else if (w_io) begin
      if (w_ofs == OW'(ERR_OFS)) begin
        w_region = REG_ERR;
      end else if (w_ofs >= OW'(IN_OFS)) begin
        if (w_ofs - OW'(IN_OFS) < OW'(N_IN))
          w_region = REG_IN;
      end else if (w_ofs - OW'(OUT_OFS) < OW'(N_OUT)) begin
        w_region = REG_OUT;
      end
    end
  end

  // Synchronise each asynchronous input port
  for (genvar k = 0; k < N_IN; k++) begin : g_in
    mem_io_sync #(.W(DATA_WIDTH)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (in_ports[k*DATA_WIDTH +: DATA_WIDTH]),
      .q   (w_in[k])
    );
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (write_enable && w_region == REG_RAM)
      r_ram[w_ram_idx] <= data_in;
  end

  // Output port registers
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_OUT; k++) begin
      if (!rst)
        r_out[k] <= '0;
      else if (write_enable && w_region == REG_OUT &&
               w_ofs == OW'(OUT_OFS + k))
        r_out[k] <= data_in;
    end
  end

  // Error set/clear terms; a new error beats a same-cycle clear
  always_comb begin
    w_set = '0;
    w_set[ERR_RW_CONFLICT] = write_enable & read_enable;
    w_set[ERR_RO_WRITE]    = write_enable & (w_region == REG_IN);
    w_set[ERR_UNMAPPED]    = (write_enable | read_enable) &
                             (w_region == REG_NONE);
    w_clr = '0;
    if (write_enable && w_region == REG_ERR)
      w_clr = data_in[2:0];
  end

  // Sticky error flags
  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= '0;
    else
      r_err <= (r_err & ~w_clr) | w_set;
  end

  // Error vector with summary bit
  always_comb begin
    w_err_vec = '0;
    w_err_vec[2:0] = r_err;
    w_err_vec[ERR_ANY] = |w_err_vec[6:0];
  end

  // Read data selection
  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_RAM: w_rdata = r_ram[w_ram_idx];
      REG_OUT: begin
        for (int k = 0; k < N_OUT; k++)
          if (w_ofs == OW'(OUT_OFS + k))
            w_rdata = r_out[k];
      end
      REG_IN: begin
        for (int k = 0; k < N_IN; k++)
          if (w_ofs == OW'(IN_OFS + k))
            w_rdata = w_in[k];
      end
      REG_ERR: w_rdata = DATA_WIDTH'(w_err_vec);
      default: w_rdata = '0;
    endcase
  end

  // Registered read response; data holds between reads
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout <= '0;
      r_rv   <= 1'b0;
    end else begin
      r_rv <= w_rd;
      if (w_rd)
        r_dout <= w_rdata;
    end
  end

  // Flatten port registers and drive the digits
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign out_ports[k*DATA_WIDTH +: DATA_WIDTH] = r_out[k];
`ifdef MEMORY_V3_SEG_DECODE_EN
    assign seg[k*7 +: 7] = hex_to_seg(r_out[k][3:0]);
`else
    assign seg[k*7 +: 7] = r_out[k][6:0];
`endif
  end

  assign data_out            = r_dout;
  assign rd_valid            = r_rv;
  assign memory_error_vector = w_err_vec;

endmodule

// File: tb/tb_memory_v3.sv
// tb_memory_v3: directed stimulus with a read-response scoreboard.
// Reads push expected data; a negedge monitor pops on rd_valid.
module tb_memory_v3;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int ND = 1024;
  localparam int NO = 8;
  localparam int NI = 4;
  localparam int IO_BASE = 4032;

  logic             clk;
  logic             rst;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    data_in;
  logic             write_enable;
  logic             read_enable;
  logic [DW-1:0]    data_out;
  logic             rd_valid;
  logic [NI*DW-1:0] in_ports;
  logic [NO*DW-1:0] out_ports;
  logic [NO*7-1:0]  seg;
  logic [7:0]       memory_error_vector;

  memory_v3 #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RAM_DEPTH  (ND),
    .N_OUT      (NO),
    .N_IN       (NI)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem_addr            (mem_addr),
    .data_in             (data_in),
    .write_enable        (write_enable),
    .read_enable         (read_enable),
    .data_out            (data_out),
    .rd_valid            (rd_valid),
    .in_ports            (in_ports),
    .out_ports           (out_ports),
    .seg                 (seg),
    .memory_error_vector (memory_error_vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] q [$];
  logic [DW-1:0] mon_exp;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid actual=1 expected=0");
      end else begin
        mon_exp = q.pop_front();
        chk("read_data", data_out, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    mem_addr = AW'(a);
    data_in = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    mem_addr = AW'(a);
    read_enable = 1'b1;
    q.push_back(e);
    tick();
    read_enable = 1'b0;
  endtask

  logic [6:0] seg1_exp;
  logic [6:0] seg7_exp;

  initial begin
`ifdef MEMORY_V3_SEG_DECODE_EN
    seg1_exp = 7'b0110000;
    seg7_exp = 7'b0001000;
`else
    seg1_exp = 7'b0000011;
    seg7_exp = 7'b1011010;
`endif
    rst = 1'b0;
    mem_addr = '0;
    data_in = '0;
    write_enable = 1'b0;
    read_enable = 1'b0;
    in_ports = '0;
    tick();
    tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_rd_valid", DW'(rd_valid), 0);
    chk("rst_out_ports", DW'(|out_ports), 0);
    chk("rst_err", DW'(memory_error_vector), 0);
    rst = 1'b1;
    tick();

    wr(5, 32'hDEADBEEF);
    rd(5, 32'hDEADBEEF);
    wr(6, 32'h12345678);
    wr(ND - 1, 32'hCAFEF00D);
    rd(6, 32'h12345678);
    rd(ND - 1, 32'hCAFEF00D);
    rd(5, 32'hDEADBEEF);

    wr(IO_BASE + 1, 32'h3);
    chk("outport1", out_ports[1*DW +: DW], 32'h3);
    chk("seg1", DW'(seg[1*7 +: 7]), DW'(seg1_exp));
    wr(IO_BASE + 7, 32'h5A);
    chk("outport7", out_ports[7*DW +: DW], 32'h5A);
    chk("seg7", DW'(seg[7*7 +: 7]), DW'(seg7_exp));
    rd(IO_BASE + 1, 32'h3);
    rd(IO_BASE + 7, 32'h5A);

    in_ports[2*DW +: DW] = 32'hA5;
    rd(IO_BASE + 34, 32'h0);
    tick();
    rd(IO_BASE + 34, 32'hA5);
    chk("err_clean", DW'(memory_error_vector), 0);

    mem_addr = AW'(7);
    data_in = 32'h11;
    write_enable = 1'b1;
    read_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    read_enable = 1'b0;
    chk("err_conflict", DW'(memory_error_vector), 32'h81);
    rd(7, 32'h11);
    rd(IO_BASE + 63, 32'h81);
    wr(IO_BASE + 63, 32'h01);
    chk("err_w1c", DW'(memory_error_vector), 0);

    wr(IO_BASE + 32, 32'hFF);
    chk("err_ro_write", DW'(memory_error_vector), 32'h82);
    rd(ND, 32'h0);
    chk("err_unmapped", DW'(memory_error_vector), 32'h86);
    rd(IO_BASE + 8, 32'h0);
    mem_addr = AW'(IO_BASE + 63);
    data_in = 32'h01;
    write_enable = 1'b1;
    read_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    read_enable = 1'b0;
    chk("err_set_wins", DW'(memory_error_vector), 32'h87);
    wr(IO_BASE + 63, 32'h7F);
    chk("err_clear_all", DW'(memory_error_vector), 0);

    mem_addr = AW'(5);
    read_enable = 1'b1;
    q.push_back(32'hDEADBEEF);
    tick();
    rst = 1'b0;
    mem_addr = AW'(6);
    tick();
    rst = 1'b1;
    read_enable = 1'b0;
    chk("mid_rst_rd_valid", DW'(rd_valid), 0);
    chk("mid_rst_out_ports", DW'(|out_ports), 0);
    chk("mid_rst_err", DW'(memory_error_vector), 0);
    rd(6, 32'h12345678);
    rd(5, 32'hDEADBEEF);

    tick();
    tick();
    tick();
    chk("queue_empty", DW'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
